// File: rtl/VX_gpu_pkg.sv
// Shared constants and types for the socket L1 memory scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package VX_gpu_pkg;

  // Source indices on the shared L1 memory port
  localparam int L1_SCHED_SRC_ICACHE = 0;
  localparam int L1_SCHED_SRC_DCACHE = 1;

  // Default geometry of the socket memory bus
  localparam int L1_SCHED_ADDR_WIDTH   = 26;
  localparam int L1_SCHED_DATA_SIZE    = 64;
  localparam int L1_SCHED_TAG_WIDTH    = 8;
  localparam int L1_SCHED_PERF_CTR_BITS = 32;

  // One memory request at default geometry; tag carries {requester tag, src}
  typedef struct packed {
    logic                              rw;
    logic [L1_SCHED_ADDR_WIDTH-1:0]    addr;
    logic [8*L1_SCHED_DATA_SIZE-1:0]   data;
    logic [L1_SCHED_DATA_SIZE-1:0]     byteen;
    logic [L1_SCHED_TAG_WIDTH:0]       tag;
  } l1_sched_req_t;

endpackage

// File: rtl/vx_l1_sched_credit.sv
// Outstanding-read counter for one source, with full/empty flags.
// Latency: flags reflect inc/dec one cycle after the edge they are sampled on.
// Backpressure: none itself; the parent stops issuing reads while full.
module vx_l1_sched_credit #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; otherwise step by one
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full  = (cnt_q == CW'(MAX));
  assign empty = (cnt_q == '0);

  // The count must never wrap in either direction
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(inc && !dec && full));
      assert (!(dec && !inc && empty));
    end
  end

endmodule

// File: rtl/vx_l1_mem_sched.sv
// Shares one L1 memory port between icache (src 0) and dcache (src 1); optional L1_SCHED_PERF_EN stall counters.
// Latency: 1 cycle request (in_req fire -> mem_req_valid), 0 cycles response (combinational routing).
// Backpressure: 1-entry output register reloads when empty or draining; reads also gated by per-source credit.
module vx_l1_mem_sched
  import VX_gpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = L1_SCHED_ADDR_WIDTH,
  parameter int DATA_SIZE    = L1_SCHED_DATA_SIZE,
  parameter int TAG_WIDTH    = L1_SCHED_TAG_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                in_req_valid,
  input  logic [1:0]                in_req_rw,
  input  logic [2*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [2*8*DATA_SIZE-1:0]  in_req_data,
  input  logic [2*DATA_SIZE-1:0]    in_req_byteen,
  input  logic [2*TAG_WIDTH-1:0]    in_req_tag,
  output logic [1:0]                in_req_ready,
  output logic [1:0]                in_rsp_valid,
  output logic [8*DATA_SIZE-1:0]    in_rsp_data,
  output logic [TAG_WIDTH-1:0]      in_rsp_tag,
  input  logic [1:0]                in_rsp_ready,
  output logic                      mem_req_valid,
  output logic                      mem_req_rw,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [8*DATA_SIZE-1:0]    mem_req_data,
  output logic [DATA_SIZE-1:0]      mem_req_byteen,
  output logic [TAG_WIDTH:0]        mem_req_tag,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [8*DATA_SIZE-1:0]    mem_rsp_data,
  input  logic [TAG_WIDTH:0]        mem_rsp_tag,
  output logic                      mem_rsp_ready,
  output logic                      busy
`ifdef L1_SCHED_PERF_EN
  ,
  output logic [1:0][L1_SCHED_PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);

  localparam int DW = 8 * DATA_SIZE;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int IC = L1_SCHED_SRC_ICACHE;
  localparam int DC = L1_SCHED_SRC_DCACHE;

  // Request as held in the output register, at this instance's geometry
  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         data;
    logic [DATA_SIZE-1:0]  byteen;
    logic [TAG_WIDTH:0]    tag;
  } req_t;

  logic [1:0]    full, empty, elig, grant, fire, rd_fire, rsp_fire;
  logic          load;
  logic          sel;
  logic          rsp_src;
  req_t          req_sel;
  req_t          out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] starve_q, starve_d;

  // Eligibility, priority grant with dcache starvation override, and load enable
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      elig[s] = in_req_valid[s] && (in_req_rw[s] || !full[s]);
    end
    if (elig == 2'b11) begin
      grant = (starve_q == SW'(STARVE_LIMIT)) ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
    // Gating with reset keeps both sources un-accepted while reset is held
    load    = (grant != 2'b00) && (!out_vld_q || mem_req_ready) && reset;
    fire    = grant & {2{load}};
    rd_fire = fire & ~in_req_rw;
  end

  assign in_req_ready = fire;

  // Mux the granted source's request; its index becomes the tag LSB
  always_comb begin
    sel            = grant[DC];
    req_sel.rw     = sel ? in_req_rw[DC] : in_req_rw[IC];
    req_sel.addr   = sel ? in_req_addr[DC*ADDR_WIDTH +: ADDR_WIDTH]
                         : in_req_addr[IC*ADDR_WIDTH +: ADDR_WIDTH];
    req_sel.data   = sel ? in_req_data[DC*DW +: DW] : in_req_data[IC*DW +: DW];
    req_sel.byteen = sel ? in_req_byteen[DC*DATA_SIZE +: DATA_SIZE]
                         : in_req_byteen[IC*DATA_SIZE +: DATA_SIZE];
    req_sel.tag    = sel ? {in_req_tag[DC*TAG_WIDTH +: TAG_WIDTH], 1'b1}
                         : {in_req_tag[IC*TAG_WIDTH +: TAG_WIDTH], 1'b0};
  end

  // Output register: refill on load, otherwise empty once memory takes it
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_d     = req_sel;
    end else if (mem_req_ready) begin
      out_vld_d = 1'b0;
    end
  end

  // Starvation count: icache wins while dcache waits, until dcache gets through
  always_comb begin
    starve_d = starve_q;
    if (fire[DC]) begin
      starve_d = '0;
    end else if (fire[IC] && elig[DC] && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Control state with reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      starve_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      starve_q  <= starve_d;
    end
  end

  // Payload register needs no reset: it is only observed while valid
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign mem_req_valid  = out_vld_q;
  assign mem_req_rw     = out_q.rw;
  assign mem_req_addr   = out_q.addr;
  assign mem_req_data   = out_q.data;
  assign mem_req_byteen = out_q.byteen;
  assign mem_req_tag    = out_q.tag;

  // Response routing on the tag's source bit
  always_comb begin
    rsp_src       = mem_rsp_tag[0];
    in_rsp_valid  = mem_rsp_valid ? (rsp_src ? 2'b10 : 2'b01) : 2'b00;
    in_rsp_tag    = mem_rsp_tag[TAG_WIDTH:1];
    in_rsp_data   = mem_rsp_data;
    mem_rsp_ready = in_rsp_ready[rsp_src];
    rsp_fire      = in_rsp_valid & in_rsp_ready;
  end

  vx_l1_sched_credit #(.MAX(MAX_PENDING)) u_credit_ic (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_fire[IC]),
    .dec   (rsp_fire[IC]),
    .full  (full[IC]),
    .empty (empty[IC])
  );

  vx_l1_sched_credit #(.MAX(MAX_PENDING)) u_credit_dc (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_fire[DC]),
    .dec   (rsp_fire[DC]),
    .full  (full[DC]),
    .empty (empty[DC])
  );

  assign busy = out_vld_q || !(&empty);

`ifdef L1_SCHED_PERF_EN
  logic [1:0][L1_SCHED_PERF_CTR_BITS-1:0] perf_q, perf_d;

  // Saturating count of cycles each source waits
  always_comb begin
    perf_d = perf_q;
    for (int s = 0; s < 2; s++) begin
      if (in_req_valid[s] && !in_req_ready[s] && (perf_q[s] != '1)) begin
        perf_d[s] = perf_q[s] + 1'b1;
      end
    end
  end

  // Stall counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vx_l1_mem_sched.sv
module tb_vx_l1_mem_sched;
  import VX_gpu_pkg::*;

  localparam int AW   = 26;
  localparam int DS   = 64;
  localparam int DW   = 8 * DS;
  localparam int TW   = 8;
  localparam int SL   = 4;
  localparam int MAXP = 16;

  logic              clk;
  logic              reset;
  logic [1:0]        in_req_valid, in_req_rw;
  logic [2*AW-1:0]   in_req_addr;
  logic [2*DW-1:0]   in_req_data;
  logic [2*DS-1:0]   in_req_byteen;
  logic [2*TW-1:0]   in_req_tag;
  logic [1:0]        in_req_ready;
  logic [1:0]        in_rsp_valid;
  logic [DW-1:0]     in_rsp_data;
  logic [TW-1:0]     in_rsp_tag;
  logic [1:0]        in_rsp_ready;
  logic              mem_req_valid, mem_req_rw;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic [DS-1:0]     mem_req_byteen;
  logic [TW:0]       mem_req_tag;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rsp_data;
  logic [TW:0]       mem_rsp_tag;
  logic              mem_rsp_ready;
  logic              busy;
`ifdef L1_SCHED_PERF_EN
  logic [1:0][L1_SCHED_PERF_CTR_BITS-1:0] perf_stall_cycles;
`endif

  vx_l1_mem_sched #(
    .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW),
    .STARVE_LIMIT(SL), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .busy(busy)
`ifdef L1_SCHED_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int s, input logic rw, input logic [AW-1:0] addr,
                           input logic [TW-1:0] tag);
    in_req_rw[s]              = rw;
    in_req_addr[s*AW +: AW]   = addr;
    in_req_tag[s*TW +: TW]    = tag;
    in_req_byteen[s*DS +: DS] = {DS{1'b1}};
    in_req_data[s*DW +: DW]   = {16{addr[7:0], tag, 16'hC0DE}};
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Combinational response-routing vectors
  typedef struct {
    logic          vld;
    logic [TW:0]   tag;
    logic [1:0]    rdy;
    logic [1:0]    e_vld;
    logic [TW-1:0] e_tag;
    logic          e_mrdy;
  } rsp_vec_t;

  rsp_vec_t tbl[6];

  // Reference model: queue-of-one output slot plus per-source outstanding-tag queues
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DS-1:0] byteen;
    logic [TW:0]   tag;
  } rec_t;

  rec_t          m_out[$];
  logic [TW-1:0] m_pend0[$];
  logic [TW-1:0] m_pend1[$];
  int            m_starve;

  initial begin
    int            pc[2];
    logic [1:0]    e, g, expr;
    logic          take;
    int            rs;
    rec_t          r;
    logic [1:0]    exp_grant;
    logic [31:0]   perf0_i, perf1_i;

    tbl[0] = '{1'b1, 9'h0B4, 2'b01, 2'b01, 8'h5A, 1'b1};
    tbl[1] = '{1'b1, 9'h0B5, 2'b01, 2'b10, 8'h5A, 1'b0};
    tbl[2] = '{1'b1, 9'h0B5, 2'b10, 2'b10, 8'h5A, 1'b1};
    tbl[3] = '{1'b0, 9'h1FF, 2'b11, 2'b00, 8'hFF, 1'b1};
    tbl[4] = '{1'b1, 9'h000, 2'b10, 2'b01, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 9'h101, 2'b11, 2'b10, 8'h80, 1'b1};

    reset = 1'b0;
    in_req_valid = 2'b11; in_req_rw = 2'b00;
    in_req_addr = '0; in_req_data = '0; in_req_byteen = '0; in_req_tag = '0;
    in_rsp_ready = 2'b00;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;

    // Reset held 3 cycles with both sources requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_in_req_ready", in_req_ready, 2'b00);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
    end

    // Response routing table (applied under reset so no state moves)
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_rsp_valid = tbl[i].vld; mem_rsp_tag = tbl[i].tag; in_rsp_ready = tbl[i].rdy;
      mem_rsp_data = {16{i[7:0], 24'hABCDEF}};
      #1;
      check("tbl_in_rsp_valid", in_rsp_valid, tbl[i].e_vld);
      check("tbl_in_rsp_tag", in_rsp_tag, tbl[i].e_tag);
      check("tbl_mem_rsp_ready", mem_rsp_ready, tbl[i].e_mrdy);
      check("tbl_in_rsp_data", in_rsp_data, {16{i[7:0], 24'hABCDEF}});
      #1 mem_rsp_valid = 1'b0; in_rsp_ready = 2'b00;
    end

    @(negedge clk);
    reset = 1'b1; in_req_valid = 2'b00;
    #1 check("post_rst_busy", busy, 1'b0);

    // Single icache read and its response
    @(negedge clk);
    drive_req(0, 1'b0, 26'h100, 8'h5A); in_req_valid = 2'b01;
    #1 check("s2_in_req_ready", in_req_ready, 2'b01);
    @(negedge clk);
    in_req_valid = 2'b00;
    #1;
    check("s2_mem_req_valid", mem_req_valid, 1'b1);
    check("s2_mem_req_tag", mem_req_tag, 9'h0B4);
    check("s2_mem_req_addr", mem_req_addr, 26'h100);
    check("s2_mem_req_rw", mem_req_rw, 1'b0);
    check("s2_busy", busy, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_tag = 9'h0B4; in_rsp_ready = 2'b01;
    #1;
    check("s2_mem_req_drained", mem_req_valid, 1'b0);
    check("s2_in_rsp_valid", in_rsp_valid, 2'b01);
    check("s2_in_rsp_tag", in_rsp_tag, 8'h5A);
    check("s2_mem_rsp_ready", mem_rsp_ready, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b0; in_rsp_ready = 2'b00;
    #1 check("s2_idle_busy", busy, 1'b0);

    // Both sources writing continuously: I,I,I,I,D repeating
    perf0_i = '0; perf1_i = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_req(0, 1'b1, 26'h1000 + 26'(i), 8'(i));
      drive_req(1, 1'b1, 26'h2000 + 26'(i), 8'(i));
      in_req_valid = 2'b11;
      #1;
`ifdef L1_SCHED_PERF_EN
      if (i == 0) begin
        perf0_i = perf_stall_cycles[0];
        perf1_i = perf_stall_cycles[1];
      end
`endif
      exp_grant = ((i % 5) == 4) ? 2'b10 : 2'b01;
      check("s3_grant", in_req_ready, exp_grant);
      if (i > 0) begin
        check("s3_mem_req_src", mem_req_tag[0], ((i - 1) % 5) == 4);
      end
    end
    @(negedge clk);
    in_req_valid = 2'b00;
    #1;
`ifdef L1_SCHED_PERF_EN
    check("s3_perf_icache", perf_stall_cycles[0] - perf0_i, 32'd3);
    check("s3_perf_dcache", perf_stall_cycles[1] - perf1_i, 32'd12);
`endif

    // dcache exhausts its 16 read credits
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_req(1, 1'b0, 26'h200 + 26'(i), 8'(i));
      in_req_valid = 2'b10;
      #1 check("s4_dc_read", in_req_ready, 2'b10);
    end
    @(negedge clk);
    drive_req(1, 1'b0, 26'h210, 8'h10);
    #1 check("s4_17th_stall", in_req_ready, 2'b00);
    @(negedge clk);
    drive_req(1, 1'b1, 26'h300, 8'h20);
    #1 check("s4_dc_write_passes", in_req_ready, 2'b10);
    @(negedge clk);
    drive_req(0, 1'b0, 26'h310, 8'h21); in_req_valid = 2'b01;
    #1 check("s4_ic_read_passes", in_req_ready, 2'b01);
    @(negedge clk);
    drive_req(1, 1'b0, 26'h210, 8'h10); in_req_valid = 2'b10;
    mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h03, 1'b1}; in_rsp_ready = 2'b10;
    #1;
    check("s4_stall_during_rsp", in_req_ready, 2'b00);
    check("s4_rsp_valid", in_rsp_valid, 2'b10);
    check("s4_rsp_tag", in_rsp_tag, 8'h03);
    @(negedge clk);
    mem_rsp_valid = 1'b0; in_rsp_ready = 2'b00;
    #1 check("s4_17th_issues", in_req_ready, 2'b10);
    @(negedge clk);
    in_req_valid = 2'b00;
    #1 check("s4_busy_pending", busy, 1'b1);
    // Reset mid-operation clears outstanding state
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("s4_reset_busy", busy, 1'b0);

    // Memory stalls for 5 cycles with a request held
    @(negedge clk);
    mem_req_ready = 1'b0;
    drive_req(0, 1'b1, 26'h300, 8'h11); in_req_valid = 2'b01;
    #1 check("s5_load", in_req_ready, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_req(0, 1'b1, 26'h301 + 26'(k), 8'h12);
      #1;
      check("s5_hold_valid", mem_req_valid, 1'b1);
      check("s5_hold_addr", mem_req_addr, 26'h300);
      check("s5_hold_tag", mem_req_tag, 9'h022);
      check("s5_hold_ready", in_req_ready, 2'b00);
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    drive_req(0, 1'b1, 26'h310, 8'h20);
    #1 check("s5_release", in_req_ready, 2'b01);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      drive_req(0, 1'b1, 26'h310 + 26'(k), 8'h20);
      #1;
      check("s5_stream_valid", mem_req_valid, 1'b1);
      check("s5_stream_addr", mem_req_addr, 26'h310 + 26'(k - 1));
      check("s5_stream_ready", in_req_ready, 2'b01);
    end
    @(negedge clk);
    in_req_valid = 2'b00;

    // Read fire and response fire on the same source in one cycle
    @(negedge clk);
    drive_req(0, 1'b0, 26'h400, 8'h33); in_req_valid = 2'b01;
    #1 check("s6_first_read", in_req_ready, 2'b01);
    @(negedge clk);
    drive_req(0, 1'b0, 26'h401, 8'h34);
    mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h33, 1'b0}; in_rsp_ready = 2'b01;
    #1;
    check("s6_read_with_rsp", in_req_ready, 2'b01);
    check("s6_rsp_ready", mem_rsp_ready, 1'b1);
    @(negedge clk);
    in_req_valid = 2'b00; mem_rsp_valid = 1'b0; in_rsp_ready = 2'b00;
    @(negedge clk);
    #1 check("s6_one_pending", busy, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h34, 1'b0}; in_rsp_ready = 2'b01;
    @(negedge clk);
    mem_rsp_valid = 1'b0; in_rsp_ready = 2'b00;
    #1 check("s6_none_pending", busy, 1'b0);

    // Randomized traffic against the reference model
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_starve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_req_valid = 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        in_req_rw[s]              = ($urandom_range(0, 3) == 0);
        in_req_addr[s*AW +: AW]   = AW'($urandom);
        in_req_tag[s*TW +: TW]    = TW'($urandom);
        in_req_byteen[s*DS +: DS] = {$urandom, $urandom};
        in_req_data[s*DW +: DW]   = rand_wide();
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      rs = $urandom_range(0, 1);
      mem_rsp_data = rand_wide();
      in_rsp_ready = 2'($urandom_range(0, 3));
      if (rs == 0 && m_pend0.size() > 0 && $urandom_range(0, 2) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_tag = {m_pend0[0], 1'b0};
      end else if (rs == 1 && m_pend1.size() > 0 && $urandom_range(0, 2) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_tag = {m_pend1[0], 1'b1};
      end else begin
        mem_rsp_valid = 1'b0; mem_rsp_tag = (TW+1)'($urandom);
      end
      #1;

      pc[0] = m_pend0.size();
      pc[1] = m_pend1.size();
      for (int s = 0; s < 2; s++) e[s] = in_req_valid[s] && (in_req_rw[s] || pc[s] < MAXP);
      if (e == 2'b11) g = (m_starve >= SL) ? 2'b10 : 2'b01;
      else g = e;
      take = (m_out.size() == 0) || mem_req_ready;
      expr = take ? g : 2'b00;

      check("rnd_in_req_ready", in_req_ready, expr);
      check("rnd_mem_req_valid", mem_req_valid, m_out.size() != 0);
      if (m_out.size() != 0) begin
        check("rnd_mem_req_hdr", {mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_tag},
              {m_out[0].rw, m_out[0].addr, m_out[0].byteen, m_out[0].tag});
        check("rnd_mem_req_data", mem_req_data, m_out[0].data);
      end
      check("rnd_busy", busy, (m_out.size() != 0) || (pc[0] + pc[1] != 0));
      check("rnd_in_rsp_valid", in_rsp_valid,
            mem_rsp_valid ? (mem_rsp_tag[0] ? 2'b10 : 2'b01) : 2'b00);
      check("rnd_in_rsp_tag", in_rsp_tag, mem_rsp_tag >> 1);
      check("rnd_mem_rsp_ready", mem_rsp_ready, in_rsp_ready[mem_rsp_tag[0]]);

      // Advance the model to the state after the coming edge
      if (m_out.size() != 0 && mem_req_ready) void'(m_out.pop_front());
      if (expr != 2'b00) begin
        rs = expr[1] ? 1 : 0;
        r.rw     = in_req_rw[rs];
        r.addr   = in_req_addr[rs*AW +: AW];
        r.data   = in_req_data[rs*DW +: DW];
        r.byteen = in_req_byteen[rs*DS +: DS];
        r.tag    = {in_req_tag[rs*TW +: TW], expr[1]};
        m_out.push_back(r);
        if (!r.rw) begin
          if (rs == 0) m_pend0.push_back(r.tag[TW:1]);
          else m_pend1.push_back(r.tag[TW:1]);
        end
        if (rs == 1) m_starve = 0;
        else if (e[1]) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
      end
      if (mem_rsp_valid && in_rsp_ready[mem_rsp_tag[0]]) begin
        if (mem_rsp_tag[0]) void'(m_pend1.pop_front());
        else void'(m_pend0.pop_front());
      end
    end

    @(negedge clk);
    in_req_valid = 2'b00; mem_rsp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
